cook_sequencer: RTL and testbench
=================================

// Module: cook_sequencer
// PURPOSE
//  Main cook controller for the microwave oven. Gates keypad entry into input_timer_control
//  (drives its enable_), captures BCD digits into a 4-digit MM:SS register on each load_
//  strobe, then counts the time down at 1 Hz while driving the magnetron.
//  Handles start/stop/clear buttons and the door interlock. Sits between input_timer_control
//  and the display/magnetron drivers.
// PARAMETERS
//  DONE_TICKS  3  number of tick_1hz periods done stays high after count reaches 00:00
//  DIGITS      4  BCD digits held (MM:SS); fixed at 4, any other value is unsupported
// PORTS
//  clock_in     in   1   system clock; all state changes on its rising edge
//  reset        in   1   synchronous, active-high reset
//  load_        in   1   active-low digit-valid from input_timer_control
//  bcd_in       in   4   BCD digit from input_timer_control; valid while load_ is 0
//  tick_1hz     in   1   one-clock_in-wide pulse, once per second
//  start_       in   1   active-low start button, pre-debounced
//  stop_        in   1   active-low stop/pause button, pre-debounced
//  clear_       in   1   active-low clear button, pre-debounced
//  door_closed  in   1   1 = door closed and latched
//  enable_      out  1   active-low keypad enable to input_timer_control
//  mag_on       out  1   magnetron drive
//  done         out  1   cook-complete indicator
//  time_bcd     out  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
//  state        out  3   current FSM state, debug/display only
// BEHAVIOUR
//  Reset: state=IDLE, time_bcd=16'h0000, enable_=0, mag_on=0, done=0, all edge-detect regs=1.
//  Edge detect: load_, start_, stop_, clear_ are registered. An event is a 1->0 transition.
//   Each press acts once. A held button does not repeat.
//  Digit entry (IDLE or SET only): on a load_ event with bcd_in<=9, shift left one digit:
//   time_bcd <= {time_bcd[11:0], bcd_in}. Then state=SET. bcd_in>9 is ignored.
//   Oldest digit is lost after the 4th entry.
//  enable_ = 0 in IDLE/SET, 1 in COOK/PAUSE/DONE. Keypad is locked while timing.
//  FSM states (shared pkg encodings): IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.
//   IDLE : load_ event -> SET.
//   SET  : start_ event, door_closed=1, time!=0 -> COOK.
//          start_ with door open or time==0 is ignored.
//          clear_ event -> IDLE, time=0.
//   COOK : mag_on=1 (combinational: state==COOK && door_closed).
//          Each tick_1hz decrements time by 1 s. Digit rules:
//           sec_ones 0->9 with borrow.
//           sec_tens 0->5 with borrow.
//           min_ones 0->9 with borrow.
//          sec_tens entered >5 counts down literally (e.g. 00:75 lasts 75 s).
//          Tick when time==00:01 -> time=0, go to DONE, done=1.
//          stop_ event or door_closed=0 -> PAUSE. Time is frozen; the tick in that cycle is ignored.
//   PAUSE: mag_on=0.
//          start_ event with door_closed=1 -> COOK.
//          clear_ or stop_ event -> IDLE, time=0.
//   DONE : done=1, mag_on=0. Counts DONE_TICKS ticks, then -> IDLE with done=0.
//          Any button event -> IDLE immediately.
//  Simultaneous events, priority high to low: clear_ > stop_ > door open > start_ > tick > load_.
//  Latency: mag_on rises 1 cycle after the start_ falling edge is sampled (2 clocks after the pin edge).
//  reset at any time, including mid-COOK, returns to reset values on the next edge.
// STRUCTURE
//  oven_pkg (shared): state localparams, BCD_MAX_ONES=9, BCD_MAX_TENS=5, TIME_ZERO=16'h0000.
//  Sub-module bcd_digit_dec (one instance per digit): inputs dec_en, max_val;
//   outputs next digit and borrow_out. These are chained by borrow.
//  FSM plus shift/edge logic stay in this module.
// TESTING
//  Digits 1,2,3,0 via load_ pulses -> time_bcd=16'h1230, state=SET, enable_=0.
//  Time 00:02, start_, 2 ticks -> mag_on=1 for 2 s, then DONE.
//   done=1 for 3 ticks, then IDLE, enable_=0.
//  Time 01:00, one tick -> 00:59. Time 10:00, one tick -> 09:59.
//  Door opened mid-COOK at 00:45 -> PAUSE, mag_on=0 same cycle, time held.
//   Close door, start_ -> COOK resumes from 00:45.
//  start_ with time=0 or door open in SET -> state stays SET, mag_on=0.
//   bcd_in=4'hA with load_ -> time unchanged.
//  clear_ and tick in same cycle during PAUSE -> IDLE, time=0.
//   reset asserted mid-COOK -> all outputs at reset values.

Source files
------------

// File: rtl/oven_pkg.sv
// Shared definitions for the microwave oven controller: FSM state encodings,
// BCD digit limits and the per-digit wrap value used by the countdown chain.
package oven_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;
  localparam logic [15:0]        TIME_ZERO    = 16'h0000;

  // Digit 1 is the seconds-tens digit; every other digit wraps to 9.
  function automatic logic [DIGIT_W-1:0] digit_max(input int idx);
    return (idx == 1) ? BCD_MAX_TENS : BCD_MAX_ONES;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown: decrements when enabled, wrapping to max_val
// and raising borrow_out when the digit was already zero.
module bcd_digit_dec
  import oven_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               dec_en,
  input  logic [DIGIT_W-1:0] max_val,
  output logic [DIGIT_W-1:0] digit_next,
  output logic               borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (dec_en) begin
      if (digit == '0) begin
        digit_next = max_val;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook controller: keypad digit capture into MM:SS, 1 Hz countdown
// with magnetron drive, start/stop/clear handling and door interlock.
module cook_sequencer
  import oven_pkg::*;
#(
  parameter int DONE_TICKS = 3,
  parameter int DIGITS     = 4
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  load_,
  input  logic [3:0]            bcd_in,
  input  logic                  tick_1hz,
  input  logic                  start_,
  input  logic                  stop_,
  input  logic                  clear_,
  input  logic                  door_closed,
  output logic                  enable_,
  output logic                  mag_on,
  output logic                  done,
  output logic [4*DIGITS-1:0]   time_bcd,
  output logic [2:0]            state
);

  localparam int CNT_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   time_q, time_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Button bits are ordered {load_, start_, stop_, clear_}.
  logic [3:0]            in_q, in_d;
  logic [3:0]            prev_q, prev_d;
  logic [3:0]            bcd_q, bcd_d;

  logic [3:0]            ev;
  logic                  ev_load, ev_start, ev_stop, ev_clear;
  logic                  load_ok, time_zero, dec_zero;
  logic [4*DIGITS-1:0]   time_dec;
  logic [DIGITS:0]       borrow;

  assign ev       = prev_q & ~in_q;
  assign ev_load  = ev[3];
  assign ev_start = ev[2];
  assign ev_stop  = ev[1];
  assign ev_clear = ev[0];

  // bcd_q is captured alongside load_ so the digit lines up with its event.
  assign load_ok   = ev_load && (bcd_q <= BCD_MAX_ONES);
  assign time_zero = (time_q == TIME_ZERO);
  assign dec_zero  = (time_dec == TIME_ZERO);

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      bcd_digit_dec u_dec (
        .digit      (time_q[4*gi +: 4]),
        .dec_en     (borrow[gi]),
        .max_val    (digit_max(gi)),
        .digit_next (time_dec[4*gi +: 4]),
        .borrow_out (borrow[gi+1])
      );
    end
  endgenerate

  always_comb begin
    in_d    = {load_, start_, stop_, clear_};
    prev_d  = in_q;
    bcd_d   = bcd_in;
    state_d = state_q;
    time_d  = time_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_SET: begin
        if (ev_clear) begin
          state_d = ST_IDLE;
          time_d  = TIME_ZERO;
        end else if (state_q == ST_SET && ev_start && door_closed && !time_zero) begin
          state_d = ST_COOK;
        end else if (load_ok) begin
          time_d  = {time_q[4*DIGITS-5:0], bcd_q};
          state_d = ST_SET;
        end
      end

      ST_COOK: begin
        if (ev_clear) begin
          state_d = ST_IDLE;
          time_d  = TIME_ZERO;
        end else if (ev_stop || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick_1hz && !borrow[DIGITS]) begin
          // A full borrow-out would mean counting below 00:00; never apply it.
          time_d = time_dec;
          if (dec_zero) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end
      end

      ST_PAUSE: begin
        if (ev_clear || ev_stop) begin
          state_d = ST_IDLE;
          time_d  = TIME_ZERO;
        end else if (ev_start && door_closed) begin
          state_d = ST_COOK;
        end
      end

      ST_DONE: begin
        if (ev_clear || ev_stop || ev_start) begin
          state_d = ST_IDLE;
        end else if (tick_1hz) begin
          if (cnt_q == CNT_W'(DONE_TICKS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        time_d  = TIME_ZERO;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      cnt_q   <= '0;
      in_q    <= '1;
      prev_q  <= '1;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      prev_q  <= prev_d;
      bcd_q   <= bcd_d;
    end
  end

  assign enable_  = !(state_q == ST_IDLE || state_q == ST_SET);
  assign mag_on   = (state_q == ST_COOK) && door_closed;
  assign done     = (state_q == ST_DONE);
  assign time_bcd = time_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed scenarios plus randomized pin activity,
// all checked every cycle against a minutes/seconds reference model.
module tb_cook_sequencer;

  localparam int S_IDLE  = 0;
  localparam int S_SET   = 1;
  localparam int S_COOK  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;
  localparam int DONE_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_n = 1'b1;
  logic [3:0]  bcd = 4'd0;
  logic        tick = 1'b0;
  logic        start_n = 1'b1;
  logic        stop_n = 1'b1;
  logic        clear_n = 1'b1;
  logic        door = 1'b1;
  logic        enable_n, mag_on, done;
  logic [15:0] time_bcd;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time held as the decimal number MMSS.
  int         m_state = S_IDLE;
  int         m_v = 0;
  int         m_dcnt = 0;
  logic [3:0] h1 = 4'hF;
  logic [3:0] h2 = 4'hF;
  logic [3:0] hbcd = 4'h0;

  always #5 clk = ~clk;

  cook_sequencer #(.DONE_TICKS(DONE_TICKS), .DIGITS(4)) dut (
    .clock_in    (clk),
    .reset       (rst),
    .load_       (load_n),
    .bcd_in      (bcd),
    .tick_1hz    (tick),
    .start_      (start_n),
    .stop_       (stop_n),
    .clear_      (clear_n),
    .door_closed (door),
    .enable_     (enable_n),
    .mag_on      (mag_on),
    .done        (done),
    .time_bcd    (time_bcd),
    .state       (state_o)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] ev;
    logic e_load, e_start, e_stop, e_clear;
    if (rst) begin
      m_state = S_IDLE;
      m_v     = 0;
      m_dcnt  = 0;
      h1      = 4'hF;
      h2      = 4'hF;
      hbcd    = 4'h0;
    end else begin
      ev      = h2 & ~h1;
      e_load  = ev[3];
      e_start = ev[2];
      e_stop  = ev[1];
      e_clear = ev[0];
      case (m_state)
        S_IDLE, S_SET: begin
          if (e_clear) begin
            m_state = S_IDLE;
            m_v     = 0;
          end else if (m_state == S_SET && e_start && door && m_v != 0) begin
            m_state = S_COOK;
          end else if (e_load && hbcd <= 4'd9) begin
            m_v     = (m_v * 10 + int'(hbcd)) % 10000;
            m_state = S_SET;
          end
        end
        S_COOK: begin
          if (e_clear) begin
            m_state = S_IDLE;
            m_v     = 0;
          end else if (e_stop || !door) begin
            m_state = S_PAUSE;
          end else if (tick) begin
            // Seconds field counts down literally; an empty field borrows a minute as 59 s.
            m_v = (m_v % 100 != 0) ? m_v - 1 : m_v - 100 + 59;
            if (m_v == 0) begin
              m_state = S_DONE;
              m_dcnt  = 0;
            end
          end
        end
        S_PAUSE: begin
          if (e_clear || e_stop) begin
            m_state = S_IDLE;
            m_v     = 0;
          end else if (e_start && door) begin
            m_state = S_COOK;
          end
        end
        S_DONE: begin
          if (e_clear || e_stop || e_start) begin
            m_state = S_IDLE;
          end else if (tick) begin
            m_dcnt++;
            if (m_dcnt == DONE_TICKS) m_state = S_IDLE;
          end
        end
        default: m_state = S_IDLE;
      endcase
      h2   = h1;
      h1   = {load_n, start_n, stop_n, clear_n};
      hbcd = bcd;
    end
  endtask

  task automatic check_outputs();
    check("state",   32'(state_o),  32'(m_state));
    check("time",    32'(time_bcd), 32'(to_bcd(m_v)));
    check("mag_on",  32'(mag_on),   32'(m_state == S_COOK && door));
    check("done",    32'(done),     32'(m_state == S_DONE));
    check("enable_", 32'(enable_n), 32'(!(m_state == S_IDLE || m_state == S_SET)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic note(input string name);
    $display("txn %-12s state=%0d time=%h mag=%0b done=%0b en_=%0b",
             name, state_o, time_bcd, mag_on, done, enable_n);
  endtask

  task automatic key(input logic [3:0] d);
    load_n = 1'b0;
    bcd    = d;
    step();
    load_n = 1'b1;
    bcd    = 4'hF;
    step();
    step();
  endtask

  // b: 0 = start_, 1 = stop_, 2 = clear_
  task automatic press(input int b);
    if (b == 0) start_n = 1'b0;
    else if (b == 1) stop_n = 1'b0;
    else clear_n = 1'b0;
    step();
    start_n = 1'b1;
    stop_n  = 1'b1;
    clear_n = 1'b1;
    step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_time", 32'(time_bcd), 32'h0);
    check("rst_enable", 32'(enable_n), 32'h0);
    note("reset");

    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    check("entry_time", 32'(time_bcd), 32'h1230);
    check("entry_state", 32'(state_o), 32'(S_SET));
    note("entry_1230");
    press(2);
    check("clear_set", 32'(time_bcd), 32'h0);

    key(4'd0); key(4'd0); key(4'd0); key(4'd2);
    press(0);
    check("start_mag", 32'(mag_on), 32'h1);
    do_tick();
    check("cook_0001", 32'(time_bcd), 32'h0001);
    do_tick();
    check("done_set", 32'(done), 32'h1);
    check("done_time", 32'(time_bcd), 32'h0);
    do_tick(); do_tick();
    check("done_held", 32'(done), 32'h1);
    do_tick();
    check("done_exit", 32'(state_o), 32'(S_IDLE));
    check("done_enable", 32'(enable_n), 32'h0);
    note("cook_0002");

    key(4'd0); key(4'd1); key(4'd0); key(4'd0);
    press(0);
    do_tick();
    check("borrow_0059", 32'(time_bcd), 32'h0059);
    press(1);
    press(2);
    note("cook_0100");

    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    press(0);
    do_tick();
    check("borrow_0959", 32'(time_bcd), 32'h0959);
    press(1);
    press(1);
    check("stop_stop", 32'(state_o), 32'(S_IDLE));
    note("cook_1000");

    key(4'd0); key(4'd0); key(4'd7); key(4'd5);
    press(0);
    repeat (16) do_tick();
    check("literal_75", 32'(time_bcd), 32'h0059);
    press(1);
    press(2);
    note("cook_0075");

    key(4'd0); key(4'd0); key(4'd4); key(4'd6);
    press(0);
    do_tick();
    door = 1'b0;
    #1;
    check("door_mag_now", 32'(mag_on), 32'h0);
    step();
    check("door_pause", 32'(state_o), 32'(S_PAUSE));
    do_tick();
    check("pause_hold", 32'(time_bcd), 32'h0045);
    door = 1'b1;
    step();
    press(0);
    check("resume_state", 32'(state_o), 32'(S_COOK));
    check("resume_time", 32'(time_bcd), 32'h0045);
    note("door_resume");

    press(1);
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("clear_tick_st", 32'(state_o), 32'(S_IDLE));
    check("clear_tick_tm", 32'(time_bcd), 32'h0);
    note("clear_tick");

    key(4'd0);
    press(0);
    check("start_zero", 32'(state_o), 32'(S_SET));
    key(4'd5);
    door = 1'b0;
    press(0);
    check("start_open", 32'(state_o), 32'(S_SET));
    check("start_open_mag", 32'(mag_on), 32'h0);
    door = 1'b1;
    key(4'hA);
    check("bad_digit", 32'(time_bcd), 32'h0005);
    note("set_guards");

    press(0);
    do_tick();
    rst = 1'b1;
    step();
    check("rst_cook_st", 32'(state_o), 32'(S_IDLE));
    check("rst_cook_tm", 32'(time_bcd), 32'h0);
    check("rst_cook_mag", 32'(mag_on), 32'h0);
    rst = 1'b0;
    step();
    note("reset_cook");

    for (int i = 0; i < 3000; i++) begin
      load_n  = ($urandom_range(0, 5) != 0);
      bcd     = 4'($urandom_range(0, 11));
      start_n = ($urandom_range(0, 9) != 0);
      stop_n  = ($urandom_range(0, 39) != 0);
      clear_n = ($urandom_range(0, 79) != 0);
      tick    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) door = ~door;
      rst     = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    note("random_done");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
